// File: rtl/key_repeat_counter_pkg.sv
// Shared types and constants for the key auto-repeat counter.
// Key patterns are {decrement, increment} levels after synchronization.
package key_repeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2,
    CLEAR  = 2'd3
  } key_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_INC  = 2'b01;
  localparam logic [1:0] K_DEC  = 2'b10;
  localparam logic [1:0] K_BOTH = 2'b11;

  // Key pattern that keeps a run going for the latched direction.
  function automatic logic [1:0] dir_key(input logic dir);
    return (dir == DIR_DN) ? K_DEC : K_INC;
  endfunction

endpackage

// File: rtl/key_repeat_counter_if.sv
// Port bundle between the key stabilizer / display path and the repeat counter.
// Handshake: key is a plain level (no valid/ready); data is always valid and
// stepPulse is a one-cycle strobe marking the cycle after data changed.
interface key_repeat_counter_if
  import key_repeat_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [1:0]       key;
  logic [WIDTH-1:0] data;
  logic             stepPulse;
  logic             repeating;
  key_state_e       state_dbg;

  modport master (output key, input data, stepPulse, repeating, state_dbg);
  modport slave  (input key, output data, stepPulse, repeating, state_dbg);
endinterface

// File: rtl/key_repeat_counter_ms_tick_gen.sv
// Millisecond prescaler: msTick is high in the last cycle of each TICK_DIV period.
// clr restarts the period so timing is measured from the most recent step.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic sysClk,
  input  logic sysRst,
  input  logic clr,
  output logic msTick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;

  assign msTick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      pre <= '0;
    end else if (clr || msTick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end
endmodule

// File: rtl/key_repeat_counter.sv
// Up/down/clear counter driven by two debounced keys, with hold-to-repeat.
// Feeds the two-digit display and float converter with the current value.
module key_repeat_counter
  import key_repeat_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int HOLD_MS   = 600,
  parameter int REPEAT_MS = 150
) (
  input logic                 sysClk,
  input logic                 sysRst,
  key_repeat_counter_if.slave kbus
);
  localparam int MAX_MS = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int CW     = $clog2(MAX_MS + 1);

  key_state_e       state, state_next;
  logic [1:0]       ks_meta, ks;
  logic             dir;
  logic             msTick;
  logic [CW-1:0]    msCnt;
  logic             hold_hit, rep_hit;
  logic             step_inc, step_dec, step_clr, dir_load, step;
  logic [WIDTH-1:0] data_q;
  logic             pulse_q, repeating_q;

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      ks_meta <= K_NONE;
      ks      <= K_NONE;
    end else begin
      ks_meta <= kbus.key;
      ks      <= ks_meta;
    end
  end

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sysClk (sysClk),
    .sysRst (sysRst),
    .clr    (step),
    .msTick (msTick)
  );

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      msCnt <= '0;
    end else if (step) begin
      msCnt <= '0;
    end else if (msTick) begin
      msCnt <= msCnt + CW'(1);
    end
  end

  // Hit on the tick that brings msCnt up to the target, i.e. exactly N ms after a step.
  assign hold_hit = msTick && (msCnt == CW'(HOLD_MS - 1));
  assign rep_hit  = msTick && (msCnt == CW'(REPEAT_MS - 1));

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ks == K_BOTH)                      state_next = CLEAR;
        else if (ks == K_INC || ks == K_DEC)   state_next = FIRST;
      end
      FIRST: begin
        if (ks == K_BOTH)                      state_next = CLEAR;
        else if (ks != dir_key(dir))           state_next = IDLE;
        else if (hold_hit)                     state_next = REPEAT;
      end
      REPEAT: begin
        if (ks == K_BOTH)                      state_next = CLEAR;
        else if (ks != dir_key(dir))           state_next = IDLE;
      end
      CLEAR: begin
        if (ks == K_NONE)                      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    step_inc = 1'b0;
    step_dec = 1'b0;
    step_clr = 1'b0;
    dir_load = 1'b0;
    unique case (state)
      IDLE: begin
        step_clr = (ks == K_BOTH);
        step_inc = (ks == K_INC);
        step_dec = (ks == K_DEC);
        dir_load = (ks == K_INC) || (ks == K_DEC);
      end
      FIRST, REPEAT: begin
        // A release or direction change in ks wins over a timer hit in the same cycle.
        if (ks == K_BOTH) begin
          step_clr = 1'b1;
        end else if (ks == dir_key(dir) &&
                     ((state == FIRST) ? hold_hit : rep_hit)) begin
          step_inc = (dir == DIR_UP);
          step_dec = (dir == DIR_DN);
        end
      end
      default: ;
    endcase
  end

  assign step = step_inc | step_dec | step_clr;

  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      dir         <= DIR_UP;
      data_q      <= '0;
      pulse_q     <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      if (dir_load) dir <= (ks == K_DEC) ? DIR_DN : DIR_UP;
      if (step_clr)      data_q <= '0;
      else if (step_inc) data_q <= data_q + WIDTH'(1);
      else if (step_dec) data_q <= data_q - WIDTH'(1);
      pulse_q     <= step;
      repeating_q <= (state_next == REPEAT);
    end
  end

  assign kbus.data      = data_q;
  assign kbus.stepPulse = pulse_q;
  assign kbus.repeating = repeating_q;
  assign kbus.state_dbg = state;
endmodule

// File: tb/tb_key_repeat_counter.sv
// Bench for key_repeat_counter: directed scenarios plus random key sequences,
// checked every cycle against a timing-rule reference model.
module tb_key_repeat_counter;
  import key_repeat_pkg::*;

  localparam int WIDTH     = 4;
  localparam int TICK_DIV  = 4;
  localparam int HOLD_MS   = 3;
  localparam int REPEAT_MS = 2;
  localparam int HOLD_CYC  = HOLD_MS * TICK_DIV;
  localparam int REP_CYC   = REPEAT_MS * TICK_DIV;
  localparam int MODV      = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_repeat_counter_if #(.WIDTH(WIDTH)) kif ();

  key_repeat_counter #(
    .WIDTH     (WIDTH),
    .TICK_DIV  (TICK_DIV),
    .HOLD_MS   (HOLD_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .sysClk (clk),
    .sysRst (rst_n),
    .kbus   (kif.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model: a run of one held key steps at its start, again HOLD_CYC
  // cycles later, and then every REP_CYC cycles, measured in run age.
  logic [1:0]       s1, s2, mk;
  int               m_data, m_age;
  logic             m_pulse, m_locked;
  logic [1:0]       m_pat;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 = K_NONE; s2 = K_NONE;
      m_data = 0; m_age = -1; m_pulse = 1'b0; m_locked = 1'b0; m_pat = K_NONE;
      exp_q.delete();
    end else begin
      mk = s2; s2 = s1; s1 = kif.key;
      m_pulse = 1'b0;
      if (m_locked) begin
        if (mk == K_NONE) m_locked = 1'b0;
      end else if (mk == K_BOTH) begin
        m_data = 0; m_pulse = 1'b1; m_locked = 1'b1; m_age = -1;
      end else if (mk == K_NONE) begin
        m_age = -1;
      end else if (m_age < 0) begin
        m_pat = mk; m_age = 0; m_pulse = 1'b1;
        m_data = (mk == K_INC) ? (m_data + 1) % MODV : (m_data + MODV - 1) % MODV;
      end else if (mk != m_pat) begin
        m_age = -1;
      end else begin
        m_age++;
        if (m_age == HOLD_CYC ||
            (m_age > HOLD_CYC && (m_age - HOLD_CYC) % REP_CYC == 0)) begin
          m_pulse = 1'b1;
          m_data = (mk == K_INC) ? (m_data + 1) % MODV : (m_data + MODV - 1) % MODV;
        end
      end
      if (m_pulse) exp_q.push_back(WIDTH'(m_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare all outputs once per cycle, away from the active edge.
  task automatic check_outputs();
    logic [WIDTH-1:0] v;
    logic             rep;
    rep = (m_age >= HOLD_CYC);
    chk("data", 32'(kif.data), 32'(m_data));
    chk("step_pulse", 32'(kif.stepPulse), 32'(m_pulse));
    chk("repeating", 32'(kif.repeating), 32'(rep));
    chk("state_is_repeat", 32'(kif.state_dbg == REPEAT), 32'(rep));
    if (kif.stepPulse === 1'b1) n_pulses++;
    if (m_pulse && exp_q.size() > 0) begin
      v = exp_q.pop_front();
      chk("step_value", 32'(kif.data), 32'(v));
    end
  endtask

  // Driver: hold a key pattern for n cycles, checking after each edge.
  task automatic run(input logic [1:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      kif.key = k;
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    int p0;
    kif.key = K_NONE;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(kif.data), 0);
    chk("reset_pulse", 32'(kif.stepPulse), 0);
    chk("reset_repeating", 32'(kif.repeating), 0);
    rst_n = 1'b1;
    run(K_NONE, 3);

    // Tap increment
    p0 = n_pulses;
    run(K_INC, 5);
    run(K_NONE, 6);
    chk("tap_data", 32'(kif.data), 1);
    chk("tap_pulses", 32'(n_pulses - p0), 1);

    // Hold increment for 60 cycles: steps at 2, 14, 22, 30, 38, 46, 54
    p0 = n_pulses;
    run(K_INC, 60);
    run(K_NONE, 6);
    chk("hold_data", 32'(kif.data), 8);
    chk("hold_pulses", 32'(n_pulses - p0), 7);

    // Wrap in both directions
    run(K_BOTH, 4);
    run(K_NONE, 6);
    chk("clear_to_zero", 32'(kif.data), 0);
    run(K_DEC, 3);
    run(K_NONE, 6);
    chk("wrap_down", 32'(kif.data), 15);
    run(K_INC, 3);
    run(K_NONE, 6);
    chk("wrap_up", 32'(kif.data), 0);

    // Clear from 7 while holding both keys
    for (int i = 0; i < 7; i++) begin
      run(K_INC, 3);
      run(K_NONE, 3);
    end
    chk("count_to_7", 32'(kif.data), 7);
    p0 = n_pulses;
    run(K_BOTH, 40);
    chk("clear_hold_data", 32'(kif.data), 0);
    chk("clear_hold_pulses", 32'(n_pulses - p0), 1);
    run(K_NONE, 6);
    run(K_INC, 3);
    run(K_NONE, 6);
    chk("after_clear_tap", 32'(kif.data), 1);

    // Direction switch out of REPEAT: 1 -> 3, then four decrements
    run(K_INC, 20);
    chk("repeat_before_switch", 32'(kif.repeating), 1);
    p0 = n_pulses;
    run(K_DEC, 30);
    run(K_NONE, 6);
    chk("switch_data", 32'(kif.data), 15);
    chk("switch_pulses", 32'(n_pulses - p0), 4);

    // Asynchronous reset in the middle of REPEAT
    run(K_INC, 20);
    chk("repeat_before_reset", 32'(kif.repeating), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_data", 32'(kif.data), 0);
    chk("async_reset_pulse", 32'(kif.stepPulse), 0);
    chk("async_reset_repeating", 32'(kif.repeating), 0);
    @(negedge clk);
    run(K_INC, 2);
    rst_n = 1'b1;
    run(K_INC, 2);
    chk("post_reset_wait", 32'(kif.data), 0);
    run(K_INC, 1);
    chk("post_reset_step", 32'(kif.data), 1);
    chk("post_reset_pulse", 32'(kif.stepPulse), 1);
    run(K_INC, 20);
    run(K_NONE, 5);

    // Random key sequences against the model
    for (int i = 0; i < 60; i++) begin
      run(2'($urandom_range(0, 3)), $urandom_range(1, 28));
    end
    run(K_NONE, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
